delay_arb: RTL

DELAY_ARB -- requirements
Module: delay_arb

---
 rtl/delay_arb_pkg.sv | 11 +
 rtl/delay_arb_rr.sv | 43 ++++
 rtl/delay_arb.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/delay_arb_pkg.sv
// Shared types and constants for the delay_arb arbiter/delay line.
package delay_arb_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } arb_state_e;

    localparam int CNT_W = 16;

endpackage

// File: rtl/delay_arb_rr.sv
// Round-robin grant logic with last-granted pointer.
module delay_arb_rr #(
    parameter int NUM_REQ = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic                       en,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] gnt_id,
    output logic                       gnt_any
);

    localparam int IDW = $clog2(NUM_REQ);

    logic [IDW-1:0] last_q;
    logic [IDW-1:0] idx;

    // Search starts one past the last winner and wraps.
    always_comb begin
        gnt     = '0;
        gnt_id  = '0;
        gnt_any = 1'b0;
        idx     = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = IDW'((int'(last_q) + 1 + off) % NUM_REQ);
            if (en && !gnt_any && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_id   = idx;
                gnt_any  = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_q <= IDW'(NUM_REQ - 1);
        end else if (gnt_any) begin
            last_q <= gnt_id;
        end
    end

endmodule

// File: rtl/delay_arb.sv
// Round-robin arbiter feeding a fixed-latency delay line with flush/drain.
// Optional per-requester grant counters under DELAY_ARB_STATS_EN.
module delay_arb
    import delay_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int DELAY_TIME = 10
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic [NUM_REQ-1:0]              i_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   i_data,
    output logic [NUM_REQ-1:0]              o_ready,
    input  logic                            i_flush,
    output logic                            o_valid,
    output logic [$clog2(NUM_REQ)-1:0]      o_id,
    output logic [DATA_WIDTH-1:0]           o_data,
    output logic [$clog2(DELAY_TIME+1)-1:0] o_inflight,
    output logic                            o_flush_done
`ifdef DELAY_ARB_STATS_EN
    ,
    output logic [NUM_REQ*CNT_W-1:0]        o_grant_cnt
`endif
);

    localparam int IDW  = $clog2(NUM_REQ);
    localparam int INFW = $clog2(DELAY_TIME + 1);

    arb_state_e state_q, state_d;

    logic                  rr_en;
    logic [NUM_REQ-1:0]    gnt;
    logic [IDW-1:0]        gnt_id;
    logic                  acc;
    logic [DATA_WIDTH-1:0] acc_data;
    logic                  exit_nxt;
    logic [INFW-1:0]       inflight_q;

    logic                  pv  [DELAY_TIME];
    logic [IDW-1:0]        pid [DELAY_TIME];
    logic [DATA_WIDTH-1:0] pd  [DELAY_TIME];

    assign rr_en = (state_q == RUN) && !i_flush;

    delay_arb_rr #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .req     (i_valid),
        .en      (rr_en),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .gnt_any (acc)
    );

    assign o_ready  = gnt;
    assign acc_data = i_data[gnt_id*DATA_WIDTH +: DATA_WIDTH];

    // Payload regs only load behind a valid beat, so the output holds.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DELAY_TIME; i++) begin
                pv[i]  <= 1'b0;
                pid[i] <= '0;
                pd[i]  <= '0;
            end
        end else begin
            pv[0] <= acc;
            if (acc) begin
                pid[0] <= gnt_id;
                pd[0]  <= acc_data;
            end
            for (int i = 1; i < DELAY_TIME; i++) begin
                pv[i] <= pv[i-1];
                if (pv[i-1]) begin
                    pid[i] <= pid[i-1];
                    pd[i]  <= pd[i-1];
                end
            end
        end
    end

    assign o_valid = pv[DELAY_TIME-1];
    assign o_id    = pid[DELAY_TIME-1];
    assign o_data  = pd[DELAY_TIME-1];

    // A beat leaves the count as it moves into the output stage.
    generate
        if (DELAY_TIME == 1) begin : g_exit_d1
            assign exit_nxt = acc;
        end else begin : g_exit_dn
            assign exit_nxt = pv[DELAY_TIME-2];
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            inflight_q <= '0;
        end else if (acc && !exit_nxt) begin
            inflight_q <= inflight_q + INFW'(1);
        end else if (!acc && exit_nxt) begin
            inflight_q <= inflight_q - INFW'(1);
        end
    end

    assign o_inflight = inflight_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        o_flush_done = 1'b0;
        unique case (state_q)
            RUN: begin
                if (i_flush) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (inflight_q == '0) begin
                    o_flush_done = 1'b1;
                    state_d      = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

`ifdef DELAY_ARB_STATS_EN
    logic [CNT_W-1:0] cnt_q [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_cnt
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                cnt_q[k] <= '0;
            end else if (gnt[k] && (cnt_q[k] != '1)) begin
                cnt_q[k] <= cnt_q[k] + CNT_W'(1);
            end
        end
        assign o_grant_cnt[k*CNT_W +: CNT_W] = cnt_q[k];
    end
`endif

endmodule
